// File: rtl/vram_pkg.sv
// Shared constants for the video RAM arbiter: requester indices, RAM geometry
// defaults and the round-robin pointer encoding.
package vram_pkg;

    localparam int VRAM_AW = 15;
    localparam int VRAM_DW = 16;

    localparam logic [VRAM_AW-1:0] SPRITE_BASE_DEFAULT = 15'h7F00;
    localparam int STARVE_LIMIT_DEFAULT = 64;

    // Requester indices, highest priority first.
    localparam int SPR  = 0;
    localparam int TILE = 1;
    localparam int CPU  = 2;
    localparam int DMA  = 3;

    // Round-robin pointer: which low-priority requester wins a tie.
    typedef enum logic {
        RR_CPU = 1'b0,
        RR_DMA = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/vram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter between CPU (req[0]) and DMA (req[1]).
// The pointer only moves when a grant is actually issued.
import vram_pkg::*;

module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    rr_ptr_e ptr;
    rr_ptr_e ptr_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= RR_CPU;
        end else begin
            ptr <= ptr_next;
        end
    end

    always_comb begin
        gnt      = 2'b00;
        ptr_next = ptr;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (ptr == RR_CPU) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
        // The winner goes to the back of the line.
        if (gnt[0]) begin
            ptr_next = RR_DMA;
        end else if (gnt[1]) begin
            ptr_next = RR_CPU;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed priority for the renderers, round-robin for
// CPU/DMA, per-requester read tags and low-priority starvation statistics.
import vram_pkg::*;

module vram_arbiter #(
    parameter int                AW           = VRAM_AW,
    parameter int                DW           = VRAM_DW,
    parameter logic [AW-1:0]     SPRITE_BASE  = SPRITE_BASE_DEFAULT,
    parameter int                STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          spr_req,
    input  logic [5:0]    spr_addr,
    input  logic          tile_req,
    input  logic [AW-1:0] tile_addr,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic [DW-1:0] ram_dout,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    output logic          spr_gnt,
    output logic          tile_gnt,
    output logic          cpu_gnt,
    output logic          dma_gnt,
    output logic          spr_rvalid,
    output logic          tile_rvalid,
    output logic          cpu_rvalid,
    output logic          dma_rvalid,
    output logic [DW-1:0] rdata,
    output logic          cpu_hold,
    output logic [7:0]    starve_cnt,
    output logic          starve
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    // Request/grant contract: a requester raises req with addr/data stable and
    // keeps them until gnt is seen in the same cycle; a granted read returns
    // rdata with its rvalid one clock later. Nothing is queued here.
    logic [1:0]    low_gnt;
    logic          low_enable;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] spr_full_addr;

    assign spr_full_addr = SPRITE_BASE | AW'(spr_addr);
    assign spr_gnt       = spr_req & ~reset;
    assign tile_gnt      = tile_req & ~spr_req & ~reset;
    assign low_enable    = ~spr_req & ~tile_req & ~reset;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .req    ({dma_req, cpu_req}),
        .enable (low_enable),
        .gnt    (low_gnt)
    );

    assign cpu_gnt  = low_gnt[0];
    assign dma_gnt  = low_gnt[1];
    assign ram_we   = (cpu_we & cpu_gnt) | (dma_we & dma_gnt);
    assign ram_din  = reset ? '0 : (cpu_gnt ? cpu_wdata : dma_wdata);
    assign rdata    = ram_dout;
    assign cpu_hold = spr_req | tile_req;

    // Idle cycles replay the last address so the RAM bus does not toggle.
    always_comb begin
        ram_addr = addr_q;
        if (spr_gnt) begin
            ram_addr = spr_full_addr;
        end else if (tile_gnt) begin
            ram_addr = tile_addr;
        end else if (cpu_gnt) begin
            ram_addr = cpu_addr;
        end else if (dma_gnt) begin
            ram_addr = dma_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            spr_rvalid  <= 1'b0;
            tile_rvalid <= 1'b0;
            cpu_rvalid  <= 1'b0;
            dma_rvalid  <= 1'b0;
        end else begin
            addr_q      <= ram_addr;
            spr_rvalid  <= spr_gnt;
            tile_rvalid <= tile_gnt;
            cpu_rvalid  <= cpu_gnt & ~cpu_we;
            dma_rvalid  <= dma_gnt & ~dma_we;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 8'd0;
            starve     <= 1'b0;
        end else begin
            if (cpu_gnt || dma_gnt || !(cpu_req || dma_req)) begin
                starve_cnt <= 8'd0;
            end else if (starve_cnt != 8'hFF) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
            starve <= (starve_cnt >= LIMIT);
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a reference grant/starvation model,
// a behavioural synchronous RAM and a scoreboard of expected read returns.
module tb_vram_arbiter;

    localparam int AW = 15;
    localparam int DW = 16;
    localparam logic [AW-1:0] SPRITE_BASE = 15'h7F00;

    logic          clk;
    logic          reset;
    logic          spr_req;
    logic [5:0]    spr_addr;
    logic          tile_req;
    logic [AW-1:0] tile_addr;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] ram_dout;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic          spr_gnt, tile_gnt, cpu_gnt, dma_gnt;
    logic          spr_rvalid, tile_rvalid, cpu_rvalid, dma_rvalid;
    logic [DW-1:0] rdata;
    logic          cpu_hold;
    logic [7:0]    starve_cnt;
    logic          starve;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {rvalid[3:0] as dma,cpu,tile,spr ; expected rdata}.
    logic [19:0]   exp_q[$];
    logic [DW-1:0] mem     [0:32767];
    logic [DW-1:0] exp_mem [0:32767];
    logic          exp_ptr;
    logic [AW-1:0] exp_addr_q;
    int            exp_cnt;
    logic          exp_starve;

    vram_arbiter dut (
        .clk(clk), .reset(reset),
        .spr_req(spr_req), .spr_addr(spr_addr),
        .tile_req(tile_req), .tile_addr(tile_addr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .spr_gnt(spr_gnt), .tile_gnt(tile_gnt), .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt),
        .spr_rvalid(spr_rvalid), .tile_rvalid(tile_rvalid),
        .cpu_rvalid(cpu_rvalid), .dma_rvalid(dma_rvalid),
        .rdata(rdata), .cpu_hold(cpu_hold), .starve_cnt(starve_cnt), .starve(starve)
    );

    // Clock / reset block and RAM_sync model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Driver tasks
    task automatic idle_inputs();
        spr_req = 0; spr_addr = '0; tile_req = 0; tile_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic model_reset();
        exp_ptr = 1'b0;
        exp_addr_q = '0;
        exp_cnt = 0;
        exp_starve = 1'b0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One arbitration cycle: inputs are already driven (posedge+1).
    task automatic tick();
        int            g;
        logic [3:0]    exp_gnt;
        logic [3:0]    rv;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_din;
        logic          exp_we;
        logic [19:0]   ent;
        #1;
        g = -1;
        if (spr_req) g = 0;
        else if (tile_req) g = 1;
        else if (cpu_req && dma_req) g = exp_ptr ? 3 : 2;
        else if (cpu_req) g = 2;
        else if (dma_req) g = 3;
        exp_gnt = 4'b0000;
        if (g >= 0) exp_gnt[g] = 1'b1;
        case (g)
            0:       exp_addr = SPRITE_BASE | {9'b0, spr_addr};
            1:       exp_addr = tile_addr;
            2:       exp_addr = cpu_addr;
            3:       exp_addr = dma_addr;
            default: exp_addr = exp_addr_q;
        endcase
        exp_we  = (g == 2 && cpu_we) || (g == 3 && dma_we);
        exp_din = (g == 2) ? cpu_wdata : dma_wdata;

        checks++;
        if ({dma_gnt, cpu_gnt, tile_gnt, spr_gnt} !== exp_gnt) begin
            errors++;
            $display("FAIL gnt: got %b expected %b at %0t", {dma_gnt, cpu_gnt, tile_gnt, spr_gnt}, exp_gnt, $time);
        end
        checks++;
        if (ram_addr !== exp_addr) begin
            errors++;
            $display("FAIL ram_addr: got %h expected %h at %0t", ram_addr, exp_addr, $time);
        end
        checks++;
        if (ram_we !== exp_we) begin
            errors++;
            $display("FAIL ram_we: got %b expected %b at %0t", ram_we, exp_we, $time);
        end
        if (exp_we) begin
            checks++;
            if (ram_din !== exp_din) begin
                errors++;
                $display("FAIL ram_din: got %h expected %h at %0t", ram_din, exp_din, $time);
            end
        end
        checks++;
        if (cpu_hold !== (spr_req | tile_req)) begin
            errors++;
            $display("FAIL cpu_hold: got %b expected %b at %0t", cpu_hold, spr_req | tile_req, $time);
        end

        rv = (g >= 0 && !exp_we) ? exp_gnt : 4'b0000;
        exp_q.push_back({rv, (rv != 0) ? exp_mem[exp_addr] : 16'h0000});

        @(posedge clk);
        if (exp_we) exp_mem[exp_addr] = exp_din;
        exp_addr_q = exp_addr;
        if (g == 2) exp_ptr = 1'b1;
        else if (g == 3) exp_ptr = 1'b0;
        exp_starve = (exp_cnt >= 64);
        if (g == 2 || g == 3 || !(cpu_req || dma_req)) exp_cnt = 0;
        else if (exp_cnt < 255) exp_cnt++;
        #1;

        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue expected one entry at %0t", $time);
        end else begin
            ent = exp_q.pop_front();
            if ({dma_rvalid, cpu_rvalid, tile_rvalid, spr_rvalid} !== ent[19:16]) begin
                errors++;
                $display("FAIL rvalid: got %b expected %b at %0t", {dma_rvalid, cpu_rvalid, tile_rvalid, spr_rvalid}, ent[19:16], $time);
            end
            if (ent[19:16] != 4'b0000) begin
                checks++;
                if (rdata !== ent[15:0]) begin
                    errors++;
                    $display("FAIL rdata: got %h expected %h at %0t", rdata, ent[15:0], $time);
                end
            end
        end
        checks++;
        if (starve_cnt !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL starve_cnt: got %0d expected %0d at %0t", starve_cnt, exp_cnt, $time);
        end
        checks++;
        if (starve !== exp_starve) begin
            errors++;
            $display("FAIL starve: got %b expected %b at %0t", starve, exp_starve, $time);
        end
    endtask

    // Scenario tasks
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 15'h1234; cpu_wdata = 16'h5555;
        tile_req = 1; tile_addr = 15'h0AAA;
        @(posedge clk);
        #2;
        checks++;
        if ({dma_gnt, cpu_gnt, tile_gnt, spr_gnt, ram_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_gnt: got %b expected 00000", {dma_gnt, cpu_gnt, tile_gnt, spr_gnt, ram_we});
        end
        checks++;
        if ({dma_rvalid, cpu_rvalid, tile_rvalid, spr_rvalid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_rvalid: got %b expected 0000", {dma_rvalid, cpu_rvalid, tile_rvalid, spr_rvalid});
        end
        checks++;
        if (ram_addr !== 15'h0 || ram_din !== 16'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr %h din %h expected 0 0", ram_addr, ram_din);
        end
        checks++;
        if (starve_cnt !== 8'd0 || starve !== 1'b0) begin
            errors++;
            $display("FAIL reset_starve: got cnt %0d starve %b expected 0 0", starve_cnt, starve);
        end
        apply_reset();
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_access();
        idle_inputs();
        cpu_req = 1; cpu_addr = 15'h0321;
        #2;
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_gnt: got %b expected 1", cpu_gnt);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (cpu_gnt !== 1'b0 || ram_addr !== 15'h0) begin
            errors++;
            $display("FAIL mid_reset_bus: got gnt %b addr %h expected 0 0", cpu_gnt, ram_addr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_rvalid: got %b expected 0", cpu_rvalid);
        end
        apply_reset();
    endtask

    task automatic test_priority();
        idle_inputs();
        spr_req = 1; spr_addr = 6'h05;
        tile_req = 1; tile_addr = 15'h0100;
        cpu_req = 1; cpu_addr = 15'h0200;
        #2;
        checks++;
        if (ram_addr !== 15'h7F05 || spr_gnt !== 1'b1) begin
            errors++;
            $display("FAIL sprite_addr: got addr %h gnt %b expected 7f05 1", ram_addr, spr_gnt);
        end
        tick();
        spr_req = 0;
        tick();
        tile_req = 0;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        apply_reset();
        cpu_req = 1; dma_req = 1;
        for (int i = 0; i < 8; i++) begin
            cpu_addr = 15'($urandom_range(0, 32767));
            dma_addr = 15'($urandom_range(0, 32767));
            tick();
        end
        dma_we = 1; dma_wdata = 16'h1357; dma_addr = 15'h4000;
        tick();
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_write_read();
        idle_inputs();
        cpu_req = 1; cpu_we = 1; cpu_addr = 15'h6000; cpu_wdata = 16'hBEEF;
        tick();
        cpu_we = 0; cpu_wdata = 16'h0000;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (mem[15'h6000] !== 16'hBEEF) begin
            errors++;
            $display("FAIL ram_content: got %h expected beef", mem[15'h6000]);
        end
    endtask

    task automatic test_starvation();
        idle_inputs();
        tile_req = 1; tile_addr = 15'h0040;
        cpu_req = 1; cpu_addr = 15'h6000;
        for (int i = 0; i < 260; i++) begin
            tile_addr = 15'($urandom_range(0, 32767));
            tick();
        end
        tile_req = 0;
        tick();
        tick();
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        cpu_req = 1;
        for (int i = 0; i < 20; i++) begin
            tile_req = (i % 2 == 0);
            tile_addr = 15'($urandom_range(0, 32767));
            cpu_addr = 15'($urandom_range(0, 32767));
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            spr_req = ($urandom_range(0, 7) == 0);
            spr_addr = 6'($urandom_range(0, 63));
            tile_req = ($urandom_range(0, 3) == 0);
            tile_addr = 15'($urandom_range(0, 32767));
            cpu_req = 1'($urandom_range(0, 1));
            cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 15'($urandom_range(0, 255));
            cpu_wdata = 16'($urandom_range(0, 65535));
            dma_req = 1'($urandom_range(0, 1));
            dma_we = 1'($urandom_range(0, 1));
            dma_addr = 15'($urandom_range(0, 255));
            dma_wdata = 16'($urandom_range(0, 65535));
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'(i) ^ 16'hC3A5;
            exp_mem[i] = 16'(i) ^ 16'hC3A5;
        end
        reset = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_reset_mid_access();
        test_priority();
        test_round_robin();
        test_write_read();
        test_starvation();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Owns the single-port 32K x 16 video RAM (RAM_sync, 1-cycle read latency).
- Shares the RAM between four requesters: the sprite scanline renderer, the tile renderer, the CPU16 and a DMA/blitter port.
- Renderers get fixed, hard-real-time priority. CPU and DMA share the leftover cycles round-robin.
- Generates per-requester grant, read-valid tags, a CPU hold signal and starvation statistics.

Parameters:
- AW, 15, RAM word-address width.
- DW, 16, RAM data width.
- SPRITE_BASE, 15'h7F00, base word address of sprite table; sprite address = SPRITE_BASE | spr_addr.
- STARVE_LIMIT, 64, consecutive denied low-priority cycles before starve flag asserts.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- spr_req  in  1  sprite renderer read request
- spr_addr  in  6  sprite table word offset
- tile_req  in  1  tile renderer read request
- tile_addr  in  AW  tile renderer word address
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write strobe
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU write data
- dma_req  in  1  DMA access request
- dma_we  in  1  DMA write strobe
- dma_addr  in  AW  DMA word address
- dma_wdata  in  DW  DMA write data
- ram_dout  in  DW  RAM read data
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_we  out  1  RAM write enable
- spr_gnt, tile_gnt, cpu_gnt, dma_gnt  out  1 each  combinational grant, same cycle as request
- spr_rvalid, tile_rvalid, cpu_rvalid, dma_rvalid  out  1 each  registered; rdata valid for the read granted the previous cycle
- rdata  out  DW  = ram_dout
- cpu_hold  out  1  = spr_req | tile_req (CPU16 hold input)
- starve_cnt  out  8  saturating count of consecutive denied low-priority cycles
- starve  out  1  registered; starve_cnt >= STARVE_LIMIT

Behaviour:
- Reset is asynchronous. While reset is high:
  - all gnt = 0, ram_we = 0, all rvalid = 0
  - starve_cnt = 0, starve = 0
  - rr_ptr = CPU
  - ram_addr = 0, ram_din = 0
- Priority, exactly one grant per cycle at most: sprite > tile > {cpu, dma}.
- Round-robin between CPU and DMA:
  - Both request and no renderer request: grant goes to rr_ptr.
  - One requests: grant it.
  - Any cpu_gnt sets rr_ptr = DMA next cycle; any dma_gnt sets rr_ptr = CPU.
  - rr_ptr is unchanged in cycles with no low-priority grant.
- Address and data muxes:
  - ram_addr follows the granted requester.
  - No grant: ram_addr holds the previous cycle's value (registered copy) to avoid spurious toggling. ram_we = 0.
  - ram_we = cpu_we & cpu_gnt | dma_we & dma_gnt. Renderers are read-only.
  - ram_din = cpu_wdata when CPU is granted, dma_wdata otherwise.
- Read tags:
  - A granted read (we = 0) sets that requester's rvalid for exactly one cycle, on the next clk edge.
  - Writes never produce rvalid.
  - Back-to-back grants give back-to-back rvalid with no bubble.
- Denied requesters must hold req/addr/data stable until granted. The arbiter does not latch requests.
- Starvation:
  - starve_cnt increments (saturating at 255) each cycle where (cpu_req | dma_req) and neither low-priority gnt is given.
  - It clears to 0 on any cpu_gnt/dma_gnt, or when no low-priority request is pending.
  - starve updates one cycle after starve_cnt.
- Simultaneous write and read target the same address: not possible, single grant per cycle.
- spr_addr maps as SPRITE_BASE | {9'b0, spr_addr}. Bits outside AW are ignored.
- Reset asserted mid-access: the pending rvalid is dropped, and requesters re-issue after reset.

Decomposition:
- Shared package vram_pkg:
  - requester index constants (SPR = 0, TILE = 1, CPU = 2, DMA = 3)
  - default SPRITE_BASE
  - AW/DW defaults
- One natural sub-module: rr_arb2, a two-way round-robin arbiter holding rr_ptr, with req[1:0] -> gnt[1:0] and an update-on-grant input. The top-level applies fixed priority over its output and owns muxes, tags and starvation.

Test Plan:
- Reset then idle: all gnt = 0, ram_we = 0, rvalid = 0, starve_cnt = 0. Assert reset mid-cycle with a pending CPU read: cpu_rvalid stays 0.
- spr_req = tile_req = cpu_req = 1, spr_addr = 6'h05: spr_gnt = 1 only, ram_addr = 15'h7F05. Next cycle spr_rvalid = 1 and rdata = word preloaded at 15'h7F05.
- cpu_req = dma_req = 1 continuously, no renderers: grants alternate CPU, DMA, CPU, DMA starting with CPU after reset.
- CPU write cpu_addr = 15'h6000, cpu_wdata = 16'hBEEF: ram_we = 1 for one cycle, cpu_rvalid stays 0. A subsequent CPU read of 15'h6000 returns 16'hBEEF with cpu_rvalid one cycle after grant.
- tile_req held high 70 cycles with cpu_req = 1:
  - cpu_hold = 1 throughout
  - starve_cnt reaches 64, starve = 1 the cycle after
  - dropping tile_req gives cpu_gnt, then starve_cnt = 0 and starve = 0
- Alternating tile/CPU reads every cycle: rvalid pulses follow grants exactly one cycle later, with no bubbles or overlaps.
